exynos4412_sequencer: RTL and testbench

//  CPU-board power/boot sequencer; peer of the DSP sequencer in the CPLD top, driven by the UFM oscillator.

---
 rtl/exynos4412_sequencer_pkg.sv | 54 +++++
 rtl/exynos4412_sequencer_if.sv | 29 ++
 rtl/exynos4412_sequencer_tick_timer.sv | 33 +++
 rtl/exynos4412_sequencer.sv | 132 +++++++++++++
 tb/tb_exynos4412_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/exynos4412_sequencer_pkg.sv
// Shared types for the Exynos4412 CPU-board power/boot sequencer: state codes,
// registered output bundle and the tick-elapsed compare used by every timed state.
package exynos4412_sequencer_pkg;

  localparam int TICK_W = 8;
  localparam int BOOT_W = 6;

  // State codes double as the LED/debug code seen by the CPLD top.
  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_PMIC_RST = 4'd1,
    ST_PWRON    = 4'd2,
    ST_WAIT_RST = 4'd3,
    ST_STRAP    = 4'd4,
    ST_HOLD     = 4'd5,
    ST_RUN      = 4'd6,
    ST_SHUTDOWN = 4'd7,
    ST_FAULT    = 4'd8
  } seq_state_t;

  typedef struct packed {
    logic pwron;
    logic pmic_reset_n;
    logic cpu_reset_n;
    logic bank_en;
    logic strap;
  } seq_out_t;

  function automatic seq_out_t state_outputs(input seq_state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      ST_PWRON:    begin o.pwron = 1'b1; o.pmic_reset_n = 1'b1; end
      ST_WAIT_RST: o.pmic_reset_n = 1'b1;
      ST_STRAP:    begin o.pmic_reset_n = 1'b1; o.bank_en = 1'b1; o.strap = 1'b1; end
      ST_HOLD:     begin o.pmic_reset_n = 1'b1; o.cpu_reset_n = 1'b1; o.bank_en = 1'b1; o.strap = 1'b1; end
      ST_RUN:      begin o.pmic_reset_n = 1'b1; o.cpu_reset_n = 1'b1; o.bank_en = 1'b1; end
      default:     o = '0;
    endcase
    return o;
  endfunction

  // States in which the board is powered and losing enable forces an orderly shutdown.
  function automatic logic in_power_path(input seq_state_t s);
    return (s >= ST_PMIC_RST) && (s <= ST_RUN);
  endfunction

  // True on the last cycle of an n-tick interval (n in 1..255).
  function automatic logic tick_elapsed(input logic tick, input logic [TICK_W-1:0] count,
                                        input int unsigned n);
    return tick && (count == TICK_W'(n - 1));
  endfunction

endpackage

// File: rtl/exynos4412_sequencer_if.sv
// Board-side signal bundle of the CPU sequencer: async status inputs from the
// CPU/PMIC side and the registered control outputs back to them.
interface exynos4412_sequencer_if;
  import exynos4412_sequencer_pkg::*;

  logic              enable;
  logic              cpu_resetout;
  logic              wreset_req;
  logic              cpu_pmic_pwron;
  logic              cpu_pmic_reset_INV;
  logic              cpu_reset_INV;
  logic              cpu_wreset_INV;
  logic              cpu_bank_en;
  logic [BOOT_W-1:0] bootmode_drv_low;
  logic [3:0]        state;

  modport master (
    input  enable, cpu_resetout, wreset_req,
    output cpu_pmic_pwron, cpu_pmic_reset_INV, cpu_reset_INV, cpu_wreset_INV,
           cpu_bank_en, bootmode_drv_low, state
  );

  modport slave (
    output enable, cpu_resetout, wreset_req,
    input  cpu_pmic_pwron, cpu_pmic_reset_INV, cpu_reset_INV, cpu_wreset_INV,
           cpu_bank_en, bootmode_drv_low, state
  );

endinterface

// File: rtl/exynos4412_sequencer_tick_timer.sv
// Prescaled tick timer: a down-counting prescaler pulses tick every TICK_DIV cycles
// and a saturating tick count follows; clear restarts both so N ticks = N*TICK_DIV cycles.
module exynos4412_sequencer_tick_timer #(
  parameter int unsigned TICK_DIV = 8192,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clear,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc;

  assign tick = (presc == '0);

  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      presc <= PRE_LOAD;
      count <= '0;
    end else if (tick) begin
      presc <= PRE_LOAD;
      if (count != '1) count <= count + 1'b1;
    end else begin
      presc <= presc - 1'b1;
    end
  end

endmodule

// File: rtl/exynos4412_sequencer.sv
// Exynos4412 CPU-board power/boot sequencer: PMIC reset/PWRON pulses, bootmode
// strapping around cold-reset release, warm reset, watchdog re-strap and shutdown.
//
//   state        | meaning
//   OFF      (0) | board unpowered, waiting for enable
//   PMIC_RST (1) | PMIC held in reset
//   PWRON    (2) | PWRON pulse to PMIC
//   WAIT_RST (3) | waiting for CPU RESETOUT, timeout -> FAULT
//   STRAP    (4) | bootmode driven, CPU still in reset
//   HOLD     (5) | CPU released, bootmode still held
//   RUN      (6) | normal operation, warm reset allowed
//   SHUTDOWN (7) | minimum off time before OFF
//   FAULT    (8) | boot timeout, parked until enable drops
module exynos4412_sequencer
  import exynos4412_sequencer_pkg::*;
#(
  parameter int unsigned       TICK_DIV       = 8192,
  parameter int unsigned       PMIC_RST_TICKS = 4,
  parameter int unsigned       PWRON_TICKS    = 250,
  parameter int unsigned       BOOT_TMO_TICKS = 255,
  parameter int unsigned       STRAP_TICKS    = 2,
  parameter int unsigned       HOLD_TICKS     = 2,
  parameter int unsigned       WRESET_TICKS   = 2,
  parameter int unsigned       OFF_TICKS      = 50,
  parameter logic [BOOT_W-1:0] BOOTMODE       = 6'b000101
) (
  input logic                     sysclk,
  input logic                     reset,
  exynos4412_sequencer_if.master  io
);

  logic en_s1, en_s2, ro_s1, ro_s2, wr_s1, wr_s2, wr_s3;
  logic wr_edge;

  seq_state_t state_q, state_nxt;
  seq_out_t   out_q, out_nxt;

  logic              st_clear, st_tick;
  logic [TICK_W-1:0] st_count;
  logic              wr_active, wr_active_nxt, wr_clear, wr_tick;
  logic [TICK_W-1:0] wr_count;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      {en_s1, en_s2, ro_s1, ro_s2, wr_s1, wr_s2, wr_s3} <= '0;
    end else begin
      en_s1 <= io.enable;
      en_s2 <= en_s1;
      ro_s1 <= io.cpu_resetout;
      ro_s2 <= ro_s1;
      wr_s1 <= io.wreset_req;
      wr_s2 <= wr_s1;
      wr_s3 <= wr_s2;
    end
  end

  assign wr_edge = wr_s2 & ~wr_s3;

  // Timers restart on every state entry; the warm-reset timer idles cleared.
  assign st_clear = (state_nxt != state_q);
  assign wr_clear = ~wr_active;

  exynos4412_sequencer_tick_timer #(.TICK_DIV(TICK_DIV), .WIDTH(TICK_W)) u_state_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (st_clear),
    .tick   (st_tick),
    .count  (st_count)
  );

  exynos4412_sequencer_tick_timer #(.TICK_DIV(TICK_DIV), .WIDTH(TICK_W)) u_wreset_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (wr_clear),
    .tick   (wr_tick),
    .count  (wr_count)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      out_q     <= state_outputs(ST_OFF);
      wr_active <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      out_q     <= out_nxt;
      wr_active <= wr_active_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_OFF:      if (en_s2) state_nxt = ST_PMIC_RST;
      ST_PMIC_RST: if (tick_elapsed(st_tick, st_count, PMIC_RST_TICKS)) state_nxt = ST_PWRON;
      ST_PWRON:    if (tick_elapsed(st_tick, st_count, PWRON_TICKS)) state_nxt = ST_WAIT_RST;
      ST_WAIT_RST: begin
        if (ro_s2) state_nxt = ST_STRAP;
        else if (tick_elapsed(st_tick, st_count, BOOT_TMO_TICKS)) state_nxt = ST_FAULT;
      end
      ST_STRAP:    if (tick_elapsed(st_tick, st_count, STRAP_TICKS)) state_nxt = ST_HOLD;
      ST_HOLD:     if (tick_elapsed(st_tick, st_count, HOLD_TICKS)) state_nxt = ST_RUN;
      ST_RUN:      if (!ro_s2) state_nxt = ST_STRAP;
      ST_SHUTDOWN: if (tick_elapsed(st_tick, st_count, OFF_TICKS)) state_nxt = ST_OFF;
      ST_FAULT:    if (!en_s2) state_nxt = ST_OFF;
      default:     state_nxt = ST_SHUTDOWN;
    endcase
    if (in_power_path(state_q) && !en_s2) state_nxt = ST_SHUTDOWN;
  end

  // Outputs decode the next state so they land on the same edge as the state register.
  always_comb begin
    out_nxt       = state_outputs(state_nxt);
    wr_active_nxt = wr_active;
    if (state_nxt != ST_RUN) begin
      wr_active_nxt = 1'b0;
    end else if (wr_active) begin
      if (tick_elapsed(wr_tick, wr_count, WRESET_TICKS)) wr_active_nxt = 1'b0;
    end else if ((state_q == ST_RUN) && wr_edge) begin
      wr_active_nxt = 1'b1;
    end
  end

  assign io.cpu_pmic_pwron     = out_q.pwron;
  assign io.cpu_pmic_reset_INV = out_q.pmic_reset_n;
  assign io.cpu_reset_INV      = out_q.cpu_reset_n;
  assign io.cpu_bank_en        = out_q.bank_en;
  assign io.cpu_wreset_INV     = ~wr_active;
  assign io.bootmode_drv_low   = out_q.strap ? ~BOOTMODE : '0;
  assign io.state              = state_q;

endmodule

// File: tb/tb_exynos4412_sequencer.sv
// Bench for exynos4412_sequencer: cycle-count reference model compared every cycle,
// plus hand-computed duration/sequence checks for the main scenarios.
module tb_exynos4412_sequencer;
  import exynos4412_sequencer_pkg::*;

  localparam int DIV = 4, T_PMIC = 2, T_PWRON = 3, T_BOOT = 5, T_STRAP = 2,
                 T_HOLD = 2, T_WR = 2, T_OFF = 3;
  localparam logic [5:0] BOOTMODE = 6'b000101;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  exynos4412_sequencer_if io();

  exynos4412_sequencer #(
    .TICK_DIV(DIV), .PMIC_RST_TICKS(T_PMIC), .PWRON_TICKS(T_PWRON), .BOOT_TMO_TICKS(T_BOOT),
    .STRAP_TICKS(T_STRAP), .HOLD_TICKS(T_HOLD), .WRESET_TICKS(T_WR), .OFF_TICKS(T_OFF),
    .BOOTMODE(BOOTMODE)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .io     (io)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: per-state output table and dwell times in plain cycles.
  int pw_tab[9]    = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
  int prst_tab[9]  = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
  int rst_tab[9]   = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
  int bank_tab[9]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
  int strap_tab[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
  int dwell[9]     = '{0, T_PMIC*DIV, T_PWRON*DIV, T_BOOT*DIV, T_STRAP*DIV, T_HOLD*DIV, 0, T_OFF*DIV, 0};
  int follow[9]    = '{0, 2, 3, 0, 5, 6, 0, 0, 0};

  int m_state = 0, m_t = 1, m_wr_left = 0, m_nxt;
  bit m_en1, m_en2, m_ro1, m_ro2, m_wr1, m_wr2, m_wr3, m_rise;

  initial begin
    forever begin
      @(posedge sysclk);
      if (reset) begin
        m_state = 0; m_t = 1; m_wr_left = 0;
        {m_en1, m_en2, m_ro1, m_ro2, m_wr1, m_wr2, m_wr3} = '0;
      end else begin
        m_rise = m_wr2 && !m_wr3;
        m_nxt  = m_state;
        case (m_state)
          0: if (m_en2) m_nxt = 1;
          3: if (m_ro2) m_nxt = 4; else if (m_t == dwell[3]) m_nxt = 8;
          6: if (!m_ro2) m_nxt = 4;
          8: if (!m_en2) m_nxt = 0;
          default: if (m_t == dwell[m_state]) m_nxt = follow[m_state];
        endcase
        if (m_state >= 1 && m_state <= 6 && !m_en2) m_nxt = 7;
        if (m_nxt != 6) m_wr_left = 0;
        else if (m_wr_left > 0) m_wr_left--;
        else if (m_state == 6 && m_rise) m_wr_left = T_WR*DIV;
        m_t     = (m_nxt == m_state) ? m_t + 1 : 1;
        m_state = m_nxt;
        m_wr3 = m_wr2; m_wr2 = m_wr1; m_wr1 = io.wreset_req;
        m_en2 = m_en1; m_en1 = io.enable;
        m_ro2 = m_ro1; m_ro1 = io.cpu_resetout;
      end
    end
  end

  // Per-cycle compare and running statistics of the DUT outputs.
  int cyc_in[16];
  int pwron_hi = 0, strap_cyc = 0, strap_rst_lo = 0, wr_lo = 0;
  int state_log[$];
  int last_st = 0;
  int act_v, exp_v;

  initial begin
    forever begin
      @(negedge sysclk);
      if (cmp_on) begin
        act_v = {io.state, io.cpu_pmic_pwron, io.cpu_pmic_reset_INV, io.cpu_reset_INV,
                 io.cpu_wreset_INV, io.cpu_bank_en, io.bootmode_drv_low};
        exp_v = {m_state[3:0], pw_tab[m_state][0], prst_tab[m_state][0], rst_tab[m_state][0],
                 (m_wr_left == 0), bank_tab[m_state][0],
                 (strap_tab[m_state] != 0) ? ~BOOTMODE : 6'b0};
        chk("outputs_vs_model", act_v, exp_v);
        cyc_in[io.state]++;
        pwron_hi += int'(io.cpu_pmic_pwron);
        if (io.bootmode_drv_low == 6'b111010) begin
          strap_cyc++;
          if (!io.cpu_reset_INV) strap_rst_lo++;
        end
        wr_lo += int'(!io.cpu_wreset_INV);
        if (int'(io.state) != last_st) begin
          state_log.push_back(int'(io.state));
          last_st = int'(io.state);
        end
      end
    end
  end

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(io.state) != s && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(io.state), s);
  endtask

  int b_pw, b_strap, b_srl, b_wr, b_log, b_s4, b_s5, b_s3, b_s7;
  int exp_seq[6] = '{1, 2, 3, 4, 5, 6};

  initial begin
    io.enable = 1'b0; io.cpu_resetout = 1'b0; io.wreset_req = 1'b0;
    step();
    cmp_on = 1;
    step(); step();
    chk("rst_state", int'(io.state), 0);
    chk("rst_pwron", int'(io.cpu_pmic_pwron), 0);
    chk("rst_pmic_reset", int'(io.cpu_pmic_reset_INV), 0);
    chk("rst_cpu_reset", int'(io.cpu_reset_INV), 0);
    chk("rst_wreset", int'(io.cpu_wreset_INV), 1);
    chk("rst_bank_en", int'(io.cpu_bank_en), 0);
    chk("rst_bootmode", int'(io.bootmode_drv_low), 0);

    // Power-up with RESETOUT arriving during PWRON.
    b_pw = pwron_hi; b_strap = strap_cyc; b_srl = strap_rst_lo; b_log = state_log.size();
    reset = 1'b0; io.enable = 1'b1;
    wait_state(2, 30, "reach_pwron");
    io.cpu_resetout = 1'b1;
    wait_state(6, 100, "reach_run");
    chk("pwron_cycles", pwron_hi - b_pw, 12);
    chk("strap_cycles", strap_cyc - b_strap, 16);
    chk("strap_to_reset_release", strap_rst_lo - b_srl, 8);
    chk("boot_seq_len", state_log.size() - b_log, 6);
    for (int i = 0; i < 6; i++)
      if (b_log + i < state_log.size()) chk("boot_seq_state", state_log[b_log + i], exp_seq[i]);

    // Warm reset with a second request inside the pulse.
    b_wr = wr_lo;
    io.wreset_req = 1'b1; step(); step();
    io.wreset_req = 1'b0; step(); step();
    io.wreset_req = 1'b1; step();
    io.wreset_req = 1'b0;
    repeat (12) step();
    chk("wreset_low_cycles", wr_lo - b_wr, 8);
    chk("wreset_idle", int'(io.cpu_wreset_INV), 1);

    // Watchdog re-strap.
    b_s4 = cyc_in[4]; b_s5 = cyc_in[5]; b_strap = strap_cyc; b_srl = strap_rst_lo;
    io.cpu_resetout = 1'b0;
    wait_state(4, 10, "restrap_enter");
    chk("restrap_reset_low", int'(io.cpu_reset_INV), 0);
    io.cpu_resetout = 1'b1;
    wait_state(6, 40, "restrap_back_to_run");
    chk("restrap_cycles", (cyc_in[4] - b_s4) + (cyc_in[5] - b_s5), 16);
    chk("restrap_strap_cycles", strap_cyc - b_strap, 16);
    chk("restrap_reset_low_cycles", strap_rst_lo - b_srl, 8);

    // Synchronous reset mid-RUN, while a warm-reset pulse is active.
    io.wreset_req = 1'b1; step(); step(); step(); step();
    chk("wreset_active_before_reset", int'(io.cpu_wreset_INV), 0);
    reset = 1'b1; step();
    chk("midrun_rst_state", int'(io.state), 0);
    chk("midrun_rst_wreset", int'(io.cpu_wreset_INV), 1);
    chk("midrun_rst_cpu_reset", int'(io.cpu_reset_INV), 0);
    chk("midrun_rst_pmic_reset", int'(io.cpu_pmic_reset_INV), 0);
    chk("midrun_rst_bank_en", int'(io.cpu_bank_en), 0);
    chk("midrun_rst_bootmode", int'(io.bootmode_drv_low), 0);

    // Boot timeout -> FAULT, then enable cycling.
    io.wreset_req = 1'b0; io.cpu_resetout = 1'b0; step();
    b_s3 = cyc_in[3]; b_log = state_log.size();
    reset = 1'b0;
    wait_state(8, 60, "reach_fault");
    chk("wait_rst_cycles", cyc_in[3] - b_s3, 20);
    io.enable = 1'b0;
    wait_state(0, 10, "fault_to_off");
    io.enable = 1'b1;
    wait_state(1, 10, "reenable_pmic_rst");
    chk("fault_seq_len", state_log.size() - b_log, 6);
    if (state_log.size() >= 3) begin
      chk("fault_seq_fault", state_log[state_log.size()-3], 8);
      chk("fault_seq_off", state_log[state_log.size()-2], 0);
    end

    // Enable drop in HOLD, re-enable inside SHUTDOWN.
    io.cpu_resetout = 1'b1;
    b_s7 = cyc_in[7];
    wait_state(5, 60, "reach_hold");
    io.enable = 1'b0;
    wait_state(7, 10, "hold_to_shutdown");
    chk("shutdown_bank_en", int'(io.cpu_bank_en), 0);
    step(); step();
    io.enable = 1'b1;
    wait_state(1, 40, "shutdown_to_pmic_rst");
    chk("shutdown_cycles", cyc_in[7] - b_s7, 12);
    if (state_log.size() >= 4) begin
      chk("shutdown_seq_hold", state_log[state_log.size()-4], 5);
      chk("shutdown_seq_off", state_log[state_log.size()-2], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
